// File: rtl/hazard_unit.sv
// Hazard controller: operand forwarding, load-use/branch stall and flush, memory-wait FSM with timeout.
// Optional performance counters enabled by defining HAZARD_PERFCNT_EN.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        PCSrcD,
    input  logic        PCSrcE,
    input  logic        PCSrcM,
    input  logic        PCSrcW,
    input  logic        BranchTakenE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles,
    output logic [31:0] MemWaitCycles
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_wcnt, w_wcnt_nxt;
    logic       r_mem_err, w_mem_err_nxt;
    logic       w_ldr_stall, w_pc_pend, w_mem_stall;

    // R15 is the PC, never a real data dependency.
    function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a == b) && (a != 4'd15);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
        if (RegWriteM && reg_match(ra, WA3M))      return 2'b10;
        else if (RegWriteW && reg_match(ra, WA3W)) return 2'b01;
        else                                       return 2'b00;
    endfunction

    assign w_ldr_stall = MemtoRegE && (reg_match(RA1D, WA3E) || reg_match(RA2D, WA3E));
    assign w_pc_pend   = PCSrcD || PCSrcE || PCSrcM;
    assign w_mem_stall = (MemReqM && !MemReadyM) || (r_state == ST_ERR);
    assign MemErr      = r_mem_err;

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_sel(RA1E);
            ForwardBE = fwd_sel(RA2E);
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else begin
                StallF = w_ldr_stall || w_pc_pend;
                StallD = w_ldr_stall;
                FlushD = w_pc_pend || PCSrcW || BranchTakenE;
                FlushE = w_ldr_stall || BranchTakenE;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_mem_err_nxt = r_mem_err;
        unique case (r_state)
            ST_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    w_state_nxt = ST_WAIT;
                    w_wcnt_nxt  = 8'd1;
                end
            end
            ST_WAIT: begin
                // A dropped request counts as completion.
                if (MemReadyM || !MemReqM) begin
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = 8'd0;
                end else if (r_wcnt == 8'(MEM_TIMEOUT)) begin
                    w_state_nxt   = ST_ERR;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end
            end
            ST_ERR: w_mem_err_nxt = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

`ifdef HAZARD_PERFCNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt, r_memwait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt   <= 32'd0;
            r_flush_cnt   <= 32'd0;
            r_memwait_cnt <= 32'd0;
        end else begin
            if (StallF)           r_stall_cnt   <= r_stall_cnt + 32'd1;
            if (FlushD || FlushE) r_flush_cnt   <= r_flush_cnt + 32'd1;
            if (w_mem_stall)      r_memwait_cnt <= r_memwait_cnt + 32'd1;
        end
    end

    assign StallCycles   = r_stall_cnt;
    assign FlushCycles   = r_flush_cnt;
    assign MemWaitCycles = r_memwait_cnt;
`else
    assign StallCycles   = 32'd0;
    assign FlushCycles   = 32'd0;
    assign MemWaitCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT=4).
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic        MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemErr;
  logic [31:0] StallCycles, FlushCycles, MemWaitCycles;

  int n_tests = 0;
  int n_fail  = 0;

  // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}
  logic [6:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

  localparam logic [6:0] C_NONE   = 7'b00000_00;
  localparam logic [6:0] C_RESET  = 7'b00000_11;
  localparam logic [6:0] C_FROZEN = 7'b11111_00;

  hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCycles(StallCycles), .FlushCycles(FlushCycles),
    .MemWaitCycles(MemWaitCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #2;
    check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    check("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    check("reset_memerr", 32'(MemErr), 32'd0);
    check("reset_cnt", StallCycles | FlushCycles | MemWaitCycles, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("idle_ctrl", 32'(ctrl), 32'(C_NONE));

    // Load-use hazard on RA1D
    MemtoRegE = 1'b1; WA3E = 4'd3; RA1D = 4'd3;
    #1;
    check("ldr_stall", 32'(ctrl), 32'(7'b11000_01));
    tick();
    MemtoRegE = 1'b0; RA1D = 4'd0; WA3E = 4'd0;
    RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3;
    #1;
    check("ldr_fwd_w", 32'(ForwardAE), 32'(2'b01));
    check("ldr_after", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();

    // Load whose destination is R15 creates no hazard
    MemtoRegE = 1'b1; WA3E = 4'd15; RA1D = 4'd15; RA2D = 4'd15;
    #1;
    check("ldr_r15", 32'(ctrl), 32'(C_NONE));
    clear_inputs();

    // Forwarding priority and R15 exclusion
    RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd5; WA3W = 4'd5; RA2E = 4'd5; RA1E = 4'd5;
    #1;
    check("fwd_b_m", 32'(ForwardBE), 32'(2'b10));
    check("fwd_a_m", 32'(ForwardAE), 32'(2'b10));
    RegWriteM = 1'b0;
    #1;
    check("fwd_b_w", 32'(ForwardBE), 32'(2'b01));
    RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA2E = 4'd15; RA1E = 4'd7;
    #1;
    check("fwd_r15", 32'({ForwardAE, ForwardBE}), 32'd0);
    clear_inputs();

    // Taken branch
    BranchTakenE = 1'b1;
    #1;
    check("branch", 32'(ctrl), 32'(7'b00000_11));
    tick();
    clear_inputs();

    // PC write travelling D->E->M->W
    PCSrcD = 1'b1; #1; check("pc_d", 32'(ctrl), 32'(7'b10000_10)); tick();
    PCSrcD = 1'b0; PCSrcE = 1'b1; #1; check("pc_e", 32'(ctrl), 32'(7'b10000_10)); tick();
    PCSrcE = 1'b0; PCSrcM = 1'b1; #1; check("pc_m", 32'(ctrl), 32'(7'b10000_10)); tick();
    PCSrcM = 1'b0; PCSrcW = 1'b1; #1; check("pc_w", 32'(ctrl), 32'(7'b00000_10)); tick();
    PCSrcW = 1'b0; #1; check("pc_done", 32'(ctrl), 32'(C_NONE));

    // Load-use coinciding with a taken branch
    MemtoRegE = 1'b1; WA3E = 4'd3; RA2D = 4'd3; BranchTakenE = 1'b1;
    #1;
    check("ldr_branch", 32'(ctrl), 32'(7'b11000_11));
    tick();
    clear_inputs();

    // Memory wait of 3 cycles; counters start from a fresh reset
    pulse_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    // A pending PC write must not flush a frozen pipeline
    PCSrcD = 1'b1;
    #1;
    check("mem_w1", 32'(ctrl), 32'(C_FROZEN));
    PCSrcD = 1'b0;
    tick(); check("mem_w2", 32'(ctrl), 32'(C_FROZEN));
    tick(); check("mem_w3", 32'(ctrl), 32'(C_FROZEN));
    tick();
    MemReadyM = 1'b1;
    #1;
    check("mem_ready", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();
    #1;
    check("mem_idle", 32'(ctrl), 32'(C_NONE));
    check("mem_noerr", 32'(MemErr), 32'd0);
`ifdef HAZARD_PERFCNT_EN
    check("cnt_memwait", MemWaitCycles, 32'd3);
    check("cnt_stall", StallCycles, 32'd3);
    check("cnt_flush", FlushCycles, 32'd0);
`else
    check("cnt_off", StallCycles | FlushCycles | MemWaitCycles, 32'd0);
`endif

    // Request dropped mid-WAIT returns to IDLE with the wait count cleared
    MemReqM = 1'b1;
    tick();
    MemReqM = 1'b0;
    #1;
    check("drop_nostall", 32'(ctrl), 32'(C_NONE));
    tick();

    // Timeout: 1 IDLE wait cycle, then 4 WAIT cycles, ERR on the following edge
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("tmo_before", 32'(MemErr), 32'd0);
    tick();
    check("tmo_err", 32'(MemErr), 32'd1);
    MemReqM = 1'b0; MemReadyM = 1'b1; BranchTakenE = 1'b1;
    #1;
    check("err_frozen", 32'(ctrl), 32'(C_FROZEN));
    tick();
    tick();
    check("err_sticky", 32'(MemErr), 32'd1);
    clear_inputs();

    // Asynchronous reset in ERR, with hazard inputs active during reset
    #2;
    reset_n = 1'b0;
    PCSrcD = 1'b1; RegWriteM = 1'b1; WA3M = 4'd2; RA1E = 4'd2;
    #1;
    check("rst_err_memerr", 32'(MemErr), 32'd0);
    check("rst_err_ctrl", 32'(ctrl), 32'(C_RESET));
    check("rst_err_fwd", 32'(ForwardAE), 32'd0);
    tick();
    clear_inputs();
    reset_n = 1'b1;
    #1;
    check("post_rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check("post_rst_cnt", StallCycles | FlushCycles | MemWaitCycles, 32'd0);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    check("post_rst_idle", 32'(ctrl), 32'(C_NONE));
    tick();
    check("post_rst_noerr", 32'(MemErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
